// File: rtl/hexdump_char_stream.sv
// Byte stream to uppercase hex text: "HH " per byte, CR LF every BYTES_PER_LINE bytes or on eof.
// Input bytes are buffered in a small FIFO; one character is emitted per cycle.
module hexdump_char_stream #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned BYTES_PER_LINE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       eof,
    output logic       wreq,
    output logic [7:0] wchar,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [PW:0]   FullCount = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LastCol   = CW'(BYTES_PER_LINE - 1);

    typedef enum logic [2:0] {StIdle, StHi, StLo, StSep, StCr, StLf} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          overflow_q;

    state_e        state_q;
    logic [7:0]    hold_q;
    logic [CW-1:0] col_q;
    logic          pend_q;
    logic          term_q;
    logic          wreq_q;
    logic [7:0]    wchar_q;

    logic full, empty, push, pop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = (state_q == StIdle) && !empty;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A pop in the same cycle does not rescue a byte offered to a full FIFO.
            if (in_valid && full) overflow_q <= 1'b1;
        end
    end

    // Outputs lag the state by one cycle, so each state's char is visible the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= 8'h00;
            col_q   <= '0;
            pend_q  <= 1'b0;
            term_q  <= 1'b0;
            wreq_q  <= 1'b0;
            wchar_q <= 8'h00;
        end else begin
            wreq_q <= 1'b0;
            if (eof) pend_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        hold_q  <= mem_q[rptr_q];
                        state_q <= StHi;
                    end else if (pend_q && col_q != '0) begin
                        term_q  <= 1'b1;
                        state_q <= StCr;
                    end else if (pend_q) begin
                        pend_q <= 1'b0;
                    end
                end
                StHi: begin
                    wreq_q  <= 1'b1;
                    wchar_q <= hex_char(hold_q[7:4]);
                    state_q <= StLo;
                end
                StLo: begin
                    wreq_q  <= 1'b1;
                    wchar_q <= hex_char(hold_q[3:0]);
                    state_q <= (col_q == LastCol) ? StCr : StSep;
                end
                StSep: begin
                    wreq_q  <= 1'b1;
                    wchar_q <= 8'h20;
                    col_q   <= col_q + 1'b1;
                    state_q <= StIdle;
                end
                StCr: begin
                    wreq_q  <= 1'b1;
                    wchar_q <= 8'h0D;
                    state_q <= StLf;
                end
                StLf: begin
                    wreq_q  <= 1'b1;
                    wchar_q <= 8'h0A;
                    col_q   <= '0;
                    // Only an eof-driven termination retires the pending flag.
                    if (term_q) begin
                        pend_q <= 1'b0;
                        term_q <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wreq     = wreq_q;
    assign wchar    = wchar_q;
    assign overflow = overflow_q;
    assign busy     = !empty || pend_q || (state_q != StIdle);

endmodule

// File: tb/tb_hexdump_char_stream.sv
// Self-checking bench for hexdump_char_stream: timing, vector table, corner sequences, random stream.
module tb_hexdump_char_stream;

    localparam int BPL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       eof;
    logic       wreq;
    logic [7:0] wchar;
    logic       busy;
    logic       overflow;

    int vectors = 0;
    int errors  = 0;
    int model_col = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic [7:0] c_hi;
        logic [7:0] c_lo;
        logic [7:0] c_sep;
    } vec_t;
    vec_t tbl[8];

    hexdump_char_stream #(.FIFO_DEPTH(16), .BYTES_PER_LINE(BPL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .eof(eof),
        .wreq(wreq), .wchar(wchar), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0 && wreq === 1'b1) got.push_back(wchar);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] hx(input int n);
        logic [7:0] digits[16];
        digits = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                   8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return digits[n % 16];
    endfunction

    function automatic int unhex(input logic [7:0] c);
        for (int i = 0; i < 16; i++) if (hx(i) == c) return i;
        return -1;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic checkint(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_q.push_back(hx(int'(b) / 16));
        exp_q.push_back(hx(int'(b) % 16));
        if (model_col == BPL - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            model_col = 0;
        end else begin
            exp_q.push_back(8'h20);
            model_col++;
        end
    endtask

    task automatic model_eof();
        if (model_col != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            model_col = 0;
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        checkint({name, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check8($sformatf("%s_char%0d", name, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy && !wreq) begin
                done = 1'b1;
                break;
            end
        end
        checkint({name, "_idle"}, int'(done), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(posedge clk);
        #1 in_valid = 1'b1; in_byte = b; eof = e;
        @(posedge clk);
        #1 in_valid = 1'b0; eof = 1'b0;
    endtask

    task automatic pulse_eof();
        @(posedge clk);
        #1 eof = 1'b1;
        @(posedge clk);
        #1 eof = 1'b0;
    endtask

    initial begin
        int dec[$];
        logic [7:0] b;
        logic e;

        tbl[0] = '{8'h3A, 8'h33, 8'h41, 8'h20};
        tbl[1] = '{8'h00, 8'h30, 8'h30, 8'h20};
        tbl[2] = '{8'hFF, 8'h46, 8'h46, 8'h20};
        tbl[3] = '{8'h9C, 8'h39, 8'h43, 8'h20};
        tbl[4] = '{8'hA5, 8'h41, 8'h35, 8'h20};
        tbl[5] = '{8'h5F, 8'h35, 8'h46, 8'h20};
        tbl[6] = '{8'hE0, 8'h45, 8'h30, 8'h20};
        tbl[7] = '{8'h1B, 8'h31, 8'h42, 8'h20};

        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; eof = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkint("rst_wreq", int'(wreq), 0);
        check8("rst_wchar", wchar, 8'h00);
        checkint("rst_busy", int'(busy), 0);
        checkint("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Exact latency of a single byte from an idle, empty state.
        @(posedge clk);
        #1 in_valid = 1'b1; in_byte = 8'h3A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkint("lat_k0_wreq", int'(wreq), 0);
        @(negedge clk);
        checkint("lat_k1_wreq", int'(wreq), 0);
        @(negedge clk);
        checkint("lat_k2_wreq", int'(wreq), 1);
        check8("lat_k2_char", wchar, 8'h33);
        @(negedge clk);
        checkint("lat_k3_wreq", int'(wreq), 1);
        check8("lat_k3_char", wchar, 8'h41);
        @(negedge clk);
        checkint("lat_k4_wreq", int'(wreq), 1);
        check8("lat_k4_char", wchar, 8'h20);
        @(negedge clk);
        checkint("lat_k5_wreq", int'(wreq), 0);
        checkint("lat_k5_busy", int'(busy), 0);
        model_col = 0;
        model_byte(8'h3A);
        pulse_eof();
        model_eof();
        wait_idle("lat_flush", 100);
        compare_stream("lat_flush");

        // Table of single bytes, each drained before the next.
        for (int i = 0; i < 8; i++) begin
            send_byte(tbl[i].b, 1'b0);
            wait_idle($sformatf("tbl%0d", i), 100);
            checkint($sformatf("tbl%0d_len", i), got.size(), 3);
            if (got.size() == 3) begin
                check8($sformatf("tbl%0d_hi", i), got[0], tbl[i].c_hi);
                check8($sformatf("tbl%0d_lo", i), got[1], tbl[i].c_lo);
                check8($sformatf("tbl%0d_sep", i), got[2], tbl[i].c_sep);
            end
            got.delete();
            model_col++;
        end
        pulse_eof();
        model_eof();
        wait_idle("tbl_flush", 100);
        compare_stream("tbl_flush");

        // Full line at one byte per four cycles.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b0);
            model_byte(8'(i));
            repeat (2) @(posedge clk);
        end
        wait_idle("line", 200);
        compare_stream("line");

        // Five bytes then eof, then an eof at column zero.
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'hC0 + i), 1'b0);
            model_byte(8'(8'hC0 + i));
        end
        pulse_eof();
        model_eof();
        wait_idle("five_eof", 200);
        compare_stream("five_eof");
        pulse_eof();
        @(negedge clk);
        checkint("eof_col0_busy_k0", int'(busy), 1);
        @(negedge clk);
        checkint("eof_col0_busy_k1", int'(busy), 0);
        repeat (4) @(negedge clk);
        checkint("eof_col0_nochars", got.size(), 0);

        // eof with the last of a burst, then a second eof while draining.
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_byte = 8'(8'h70 + i); eof = (i == 5);
            model_byte(8'(8'h70 + i));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; eof = 1'b0;
        model_eof();
        repeat (2) @(posedge clk);
        #1 eof = 1'b1;
        @(posedge clk);
        #1 eof = 1'b0;
        wait_idle("eof_burst", 200);
        repeat (6) @(negedge clk);
        compare_stream("eof_burst");

        // Sustained input overruns the FIFO.
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_byte = 8'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle("ovf", 400);
        checkint("ovf_flag", int'(overflow), 1);
        dec.delete();
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] != 8'h20 && got[i] != 8'h0D && got[i] != 8'h0A) begin
                if (i + 1 < got.size()) dec.push_back(unhex(got[i]) * 16 + unhex(got[i+1]));
                i++;
            end
        end
        checkint("ovf_some_dropped", int'(dec.size() >= 17 && dec.size() <= 39), 1);
        for (int i = 0; i < dec.size(); i++) begin
            if (i < 17) checkint($sformatf("ovf_byte%0d", i), dec[i], i);
            else checkint($sformatf("ovf_order%0d", i), int'(dec[i] > dec[i-1]), 1);
            model_byte(8'(dec[i]));
        end
        compare_stream("ovf_stream");
        pulse_eof();
        model_eof();
        wait_idle("ovf_flush", 100);
        compare_stream("ovf_flush");

        // Reset while the low nibble is being produced.
        send_byte(8'h12, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkint("rst_lo_wreq", int'(wreq), 0);
        checkint("rst_lo_busy", int'(busy), 0);
        checkint("rst_lo_overflow", int'(overflow), 0);
        got.delete();
        repeat (8) @(negedge clk);
        checkint("rst_lo_silent", got.size(), 0);
        model_col = 0;
        send_byte(8'hFF, 1'b0);
        model_byte(8'hFF);
        wait_idle("rst_ff", 100);
        compare_stream("rst_ff");

        // Random stream against the model, occasional eof with a byte.
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            b = 8'($urandom_range(0, 255));
            e = ($urandom_range(0, 19) == 0);
            send_byte(b, e);
            model_byte(b);
            if (e) begin
                model_eof();
                wait_idle("rnd_eof", 200);
                compare_stream("rnd_eof");
            end
        end
        pulse_eof();
        model_eof();
        wait_idle("rnd_end", 400);
        compare_stream("rnd_end");
        checkint("rnd_no_overflow", int'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
